// File: rtl/spi_mnrch_cfg_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// spi_mnrch_cfg_if : host-side start/result bundle for spi_mnrch_cfg. Rev 1.0
// -----------------------------------------------------------------------------
interface spi_mnrch_cfg_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 1
);
  logic              wrt;
  logic [DATA_W-1:0] wrt_data;
  logic [SEL_W-1:0]  ss_sel;
  logic              cpol;
  logic              cpha;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first;
`endif
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              busy;

`ifdef SPI_LSB_FIRST_EN
  modport master (output wrt, wrt_data, ss_sel, cpol, cpha, lsb_first,
                  input  rd_data, done, busy);
  modport slave  (input  wrt, wrt_data, ss_sel, cpol, cpha, lsb_first,
                  output rd_data, done, busy);
`else
  modport master (output wrt, wrt_data, ss_sel, cpol, cpha,
                  input  rd_data, done, busy);
  modport slave  (input  wrt, wrt_data, ss_sel, cpol, cpha,
                  output rd_data, done, busy);
`endif
endinterface
`default_nettype wire

// File: rtl/spi_mnrch_cfg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// spi_mnrch_cfg : SPI master, per-transfer CPOL/CPHA, one word per wrt. Rev 1.0
// Macro SPI_LSB_FIRST_EN adds bus.lsb_first for LSB-first transfers.
// -----------------------------------------------------------------------------
module spi_mnrch_cfg #(
  parameter int DATA_W   = 16,
  parameter int SCLK_DIV = 32,
  parameter int NUM_SS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_mnrch_cfg_if.slave      bus,
  output logic [NUM_SS-1:0]   SS_n,
  output logic                SCLK,
  output logic                MOSI,
  input  logic                MISO
);
  localparam int H     = SCLK_DIV / 2;
  localparam int DIV_W = (H > 1) ? $clog2(H) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [BIT_W-1:0]  bitcnt;
  logic              phase;   // 0: next half-period boundary is a leading edge (or the end)
  logic [DATA_W-1:0] sr;
  logic              sample;
  logic              cpol_q;
  logic              cpha_q;
  logic              lsb_q;
  logic              lsb_start;
  logic [DATA_W-1:0] sr_shift;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_start = bus.lsb_first;
`else
  assign lsb_start = 1'b0;
  assign lsb_q     = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                 input logic b, input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  function automatic logic tx_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  assign sr_shift = shift_in(sr, sample, lsb_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div         <= '0;
      bitcnt      <= '0;
      phase       <= 1'b0;
      sr          <= '0;
      sample      <= 1'b0;
      cpol_q      <= 1'b1;
      cpha_q      <= 1'b1;
`ifdef SPI_LSB_FIRST_EN
      lsb_q       <= 1'b0;
`endif
      SS_n        <= '1;
      SCLK        <= 1'b1;
      MOSI        <= 1'b0;
      bus.done    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.wrt) begin
            sr     <= bus.wrt_data;
            MOSI   <= tx_bit(bus.wrt_data, lsb_start);
            cpol_q <= bus.cpol;
            cpha_q <= bus.cpha;
`ifdef SPI_LSB_FIRST_EN
            lsb_q  <= lsb_start;
`endif
            SCLK   <= bus.cpol;
            // An out-of-range index selects nothing; the transfer still runs.
            for (int i = 0; i < NUM_SS; i++)
              SS_n[i] <= (int'(bus.ss_sel) != i);
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
            div      <= '0;
            bitcnt   <= '0;
            phase    <= 1'b0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (div != DIV_W'(H - 1)) begin
            div <= div + DIV_W'(1);
          end else begin
            div <= '0;
            if (!phase) begin
              if (bitcnt == BIT_W'(DATA_W)) begin
                // CPHA=1 owes one final shift of the last trailing-edge sample.
                if (cpha_q) begin
                  sr          <= sr_shift;
                  MOSI        <= tx_bit(sr_shift, lsb_q);
                  bus.rd_data <= sr_shift;
                end else begin
                  bus.rd_data <= sr;
                end
                SS_n     <= '1;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                state    <= IDLE;
              end else begin
                SCLK  <= ~cpol_q;
                phase <= 1'b1;
                if (!cpha_q) begin
                  sample <= MISO;
                end else if (bitcnt != '0) begin
                  sr   <= sr_shift;
                  MOSI <= tx_bit(sr_shift, lsb_q);
                end
              end
            end else begin
              SCLK   <= cpol_q;
              phase  <= 1'b0;
              bitcnt <= bitcnt + BIT_W'(1);
              if (!cpha_q) begin
                sr   <= sr_shift;
                MOSI <= tx_bit(sr_shift, lsb_q);
              end else begin
                sample <= MISO;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_spi_mnrch_cfg.sv
`default_nettype none
// tb_spi_mnrch_cfg : directed and randomized transfers checked every cycle
// against a timeline model of SCLK/MOSI/SS_n/busy/done/rd_data.
module tb_spi_mnrch_cfg;
  localparam int DW    = 16;
  localparam int DIV   = 32;
  localparam int H     = DIV / 2;
  localparam int NSS   = 3;
  localparam int SW    = 2;
  localparam int LIMIT = 2000;
  localparam int END_T = (2 * DW + 1) * H;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NSS-1:0] SS_n;
  logic           SCLK;
  logic           MOSI;
  logic           MISO  = 1'b0;

  spi_mnrch_cfg_if #(.DATA_W(DW), .SEL_W(SW)) bus ();

  spi_mnrch_cfg #(.DATA_W(DW), .SCLK_DIV(DIV), .NUM_SS(NSS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .SS_n (SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int passes  = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model: time offset since start ----------------
  bit             m_active = 1'b0;
  bit             m_done   = 1'b0;
  bit             m_cpol   = 1'b1;
  bit             m_cpha   = 1'b1;
  bit             m_lsb    = 1'b0;
  int             m_t      = 0;
  logic [DW-1:0]  m_tx     = '0;
  logic [DW-1:0]  m_rd     = '0;
  logic [SW-1:0]  m_sel    = '0;
  bit             m_rx [DW];

  always @(posedge clk or negedge rst_n) begin : mdl
    int first;
    if (!rst_n) begin
      m_active = 1'b0; m_done = 1'b0; m_cpol = 1'b1; m_cpha = 1'b1;
      m_lsb = 1'b0; m_rd = '0; m_t = 0;
    end else if (m_active) begin
      m_t++;
      first = m_cpha ? 2 * H : H;
      if (m_t >= first && (m_t - first) % (2 * H) == 0 && (m_t - first) / (2 * H) < DW)
        m_rx[(m_t - first) / (2 * H)] = MISO;
      if (m_t == END_T) begin
        m_active = 1'b0;
        m_done   = 1'b1;
        for (int k = 0; k < DW; k++) m_rd[m_lsb ? k : DW - 1 - k] = m_rx[k];
      end
    end else if (bus.wrt === 1'b1) begin
      m_tx = bus.wrt_data; m_cpol = bus.cpol; m_cpha = bus.cpha; m_sel = bus.ss_sel;
`ifdef SPI_LSB_FIRST_EN
      m_lsb = bus.lsb_first;
`else
      m_lsb = 1'b0;
`endif
      for (int k = 0; k < DW; k++) m_rx[k] = 1'b0;
      m_t = 0; m_active = 1'b1; m_done = 1'b0;
    end
  end

  function automatic int shifts_done();
    int first, n;
    first = m_cpha ? 3 * H : 2 * H;
    if (m_t < first) return 0;
    n = (m_t - first) / (2 * H) + 1;
    return (n > DW) ? DW : n;
  endfunction

  function automatic logic exp_sclk();
    if (m_active && m_t >= H && m_t < 2 * H * DW && ((m_t - H) / H) % 2 == 0) return !m_cpol;
    return m_cpol;
  endfunction

  function automatic logic exp_mosi();
    int j;
    j = shifts_done();
    if (j < DW) return m_lsb ? m_tx[j] : m_tx[DW - 1 - j];
    return m_rx[0];
  endfunction

  function automatic logic [NSS-1:0] exp_ss();
    logic [NSS-1:0] one;
    one = 1;
    if (m_active && int'(m_sel) < NSS) return ~(one << m_sel);
    return '1;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    logic [22:0] got, exp;
    if (started) begin
      got = {bus.busy, bus.done, SS_n, SCLK, m_active ? MOSI : 1'b0, m_done ? bus.rd_data : 16'h0};
      exp = {m_active, m_done, exp_ss(), exp_sclk(), m_active ? exp_mosi() : 1'b0,
             m_done ? m_rd : 16'h0};
      chk("cycle{busy,done,ss_n,sclk,mosi,rd}", {9'b0, got}, {9'b0, exp});
    end
  end

  // ---------------- MISO driver / mode-0 slave ----------------
  int            miso_mode = 0;  // 0 random, 1 loopback, 2 mode-0 slave
  int            idx       = 0;
  int            nrise     = 0;
  logic          sclk_prev = 1'b1;
  logic [DW-1:0] slave_tx  = '0;
  logic [DW-1:0] slave_rx  = '0;

  always @(negedge clk) begin
    if (miso_mode != 2 || SS_n[0]) begin
      idx = 0; nrise = 0; slave_rx = '0;
    end else if (SCLK !== sclk_prev) begin
      if (SCLK) begin slave_rx = {slave_rx[DW-2:0], MOSI}; nrise++; end
      else if (nrise > 0) idx++;
    end
    sclk_prev = SCLK;
    case (miso_mode)
      1:       MISO = MOSI;
      2:       MISO = (idx < DW) ? slave_tx[DW - 1 - idx] : 1'b0;
      default: MISO = 1'($urandom);
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic start(input logic [DW-1:0] d, input logic pol, input logic pha,
                       input logic [SW-1:0] sel, input logic lsb);
    @(negedge clk);
    bus.wrt_data = d; bus.cpol = pol; bus.cpha = pha; bus.ss_sel = sel;
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = lsb;
`else
    if (lsb) $display("note: lsb_first requested in an MSB-only build");
`endif
    bus.wrt = 1'b1;
    @(negedge clk);
    bus.wrt = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int edges, output int first);
    logic prev;
    prev = SCLK; cyc = 0; edges = 0; first = -1;
    while (bus.done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (SCLK !== prev) begin edges++; if (first < 0) first = cyc; end
      prev = SCLK;
    end
    chk("done_within_limit", 32'(cyc < LIMIT), 32'd1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, edges, first, w;
    logic [DW-1:0] d;
    bus.wrt = 1'b0; bus.wrt_data = '0; bus.ss_sel = '0; bus.cpol = 1'b1; bus.cpha = 1'b1;
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_ss_n", 32'(SS_n), 32'h7);
    chk("reset_sclk", 32'(SCLK), 32'h1);
    chk("reset_mosi", 32'(MOSI), 32'h0);
    chk("reset_busy_done", {30'b0, bus.busy, bus.done}, 32'h0);
    chk("reset_rd_data", 32'(bus.rd_data), 32'h0);
    rst_n = 1'b1; started = 1'b1;

    // Mode 3 loopback
    miso_mode = 1;
    start(16'hA5C3, 1'b1, 1'b1, 2'd0, 1'b0);
    wait_done(cyc, edges, first);
    chk("m3_done_t", 32'(cyc), 32'd528);
    chk("m3_sclk_edges", 32'(edges), 32'd32);
    chk("m3_first_fall_t", 32'(first), 32'd16);
    chk("m3_rd_data", 32'(bus.rd_data), 32'hA5C3);

    // Mode 0 against a slave returning 1234
    miso_mode = 2; slave_tx = 16'h1234;
    start(16'hBEEF, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("m0_sclk_idle_start", 32'(SCLK), 32'h0);
    wait_done(cyc, edges, first);
    chk("m0_rd_data", 32'(bus.rd_data), 32'h1234);
    chk("m0_slave_rx", 32'(slave_rx), 32'hBEEF);
    chk("m0_sclk_idle_end", 32'(SCLK), 32'h0);

    // Slave selects: in range and out of range
    miso_mode = 0;
    start(16'h5A5A, 1'b1, 1'b0, 2'd2, 1'b0);
    chk("ss_sel2_active", 32'(SS_n), 32'h3);
    wait_done(cyc, edges, first);
    chk("ss_sel2_done_t", 32'(cyc), 32'd528);
    chk("ss_sel2_idle", 32'(SS_n), 32'h7);
    start(16'h0F0F, 1'b0, 1'b1, 2'd3, 1'b0);
    chk("ss_sel3_active", 32'(SS_n), 32'h7);
    wait_done(cyc, edges, first);
    chk("ss_sel3_done_t", 32'(cyc), 32'd528);

    // wrt while busy is ignored; wrt in the done cycle starts a new transfer
    miso_mode = 1;
    start(16'h3C5A, 1'b0, 1'b1, 2'd1, 1'b0);
    repeat (100) @(negedge clk);
    bus.wrt_data = 16'hFFFF; bus.cpol = 1'b1; bus.cpha = 1'b0; bus.ss_sel = 2'd2; bus.wrt = 1'b1;
    @(negedge clk);
    bus.wrt = 1'b0;
    wait_done(cyc, edges, first);
    chk("busy_wrt_rd_data", 32'(bus.rd_data), 32'h3C5A);
    bus.wrt_data = 16'h0F0F; bus.cpol = 1'b1; bus.cpha = 1'b1; bus.ss_sel = 2'd0; bus.wrt = 1'b1;
    @(negedge clk);
    bus.wrt = 1'b0;
    chk("done_cycle_wrt_done", 32'(bus.done), 32'h0);
    chk("done_cycle_wrt_busy", 32'(bus.busy), 32'h1);
    wait_done(cyc, edges, first);
    chk("done_cycle_wrt_rd", 32'(bus.rd_data), 32'h0F0F);

    // Reset mid-transfer
    start(16'h8421, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (200) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ss_n", 32'(SS_n), 32'h7);
    chk("midrst_sclk", 32'(SCLK), 32'h1);
    chk("midrst_busy_done", {30'b0, bus.busy, bus.done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    start(16'hC001, 1'b1, 1'b1, 2'd1, 1'b0);
    wait_done(cyc, edges, first);
    chk("after_rst_done_t", 32'(cyc), 32'd528);
    chk("after_rst_rd", 32'(bus.rd_data), 32'hC001);

`ifdef SPI_LSB_FIRST_EN
    start(16'h0001, 1'b1, 1'b1, 2'd0, 1'b1);
    chk("lsb_first_mosi", 32'(MOSI), 32'h1);
    wait_done(cyc, edges, first);
    chk("lsb_first_rd", 32'(bus.rd_data), 32'h0001);
`endif

    // Randomized transfers with spurious wrt and mode changes mid-transfer
    repeat (24) begin
      miso_mode = int'($urandom_range(0, 1));
      d = DW'($urandom);
      start(d, 1'($urandom), 1'($urandom), SW'($urandom_range(0, 3)), 1'($urandom));
      w = int'($urandom_range(1, 400));
      repeat (w) @(negedge clk);
      bus.wrt_data = DW'($urandom); bus.cpol = 1'($urandom); bus.cpha = 1'($urandom);
      bus.ss_sel = SW'($urandom);
      bus.wrt = 1'($urandom);
      @(negedge clk);
      bus.wrt = 1'b0;
      wait_done(cyc, edges, first);
      if (miso_mode == 1) chk("rand_loopback_rd", 32'(bus.rd_data), 32'(d));
      repeat (int'($urandom_range(0, 4))) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/spi_mnrch_cfg.md
Name: spi_mnrch_cfg

Overview:
Parametrised SPI master (monarch) with configurable word width, SCLK divider and slave-select count. SPI mode (CPOL/CPHA) is selectable per transfer. It is the general-purpose serial front end for inertial/peripheral sensors: one wrt pulse starts one full-duplex word transfer, and done flags completion with rd_data valid. Sits between sensor-interface state machines and the off-chip SPI pins.

Parameters:
DATA_W, 16, bits per transfer; legal range >= 2
SCLK_DIV, 32, clk cycles per SCLK period; must be even and >= 4; H = SCLK_DIV/2
NUM_SS, 1, number of slave-select lines; SEL_W = max(1, clog2(NUM_SS))

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wrt  in  1  start pulse; accepted only when busy=0
wrt_data  in  DATA_W  word to transmit; captured on accepted wrt
ss_sel  in  SEL_W  slave index; captured on accepted wrt
cpol  in  1  SCLK idle level; captured on accepted wrt
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; captured on accepted wrt
rd_data  out  DATA_W  received word; valid while done=1
done  out  1  transfer complete; level, held until next accepted wrt
busy  out  1  high from the cycle after an accepted wrt until done rises
SS_n  out  NUM_SS  active-low slave selects
SCLK  out  1  serial clock
MOSI  out  1  serial data out
MISO  in  1  serial data in

Behaviour:
- Reset values: SS_n all 1, SCLK 1, MOSI 0, done 0, busy 0, rd_data 0. Captured mode register resets to CPOL=1, CPHA=1.
- States: IDLE, XFER. The SCLK divider counter, bit counter and shift register are all registered; every output is driven directly from a flop.
- IDLE: SCLK = captured cpol. On wrt, on the next edge:
  - shift register <= wrt_data; mode and ss_sel are latched.
  - SS_n[ss_sel] <= 0; if ss_sel >= NUM_SS, SS_n stays all high but the transfer still runs.
  - busy <= 1; done <= 0; state <= XFER. Call this cycle t=0.
- MSB first. MOSI = shift register MSB for the whole transfer.
- SCLK edges: leading edge (cpol -> ~cpol) at t = H + 2H*k; trailing edge (back to cpol) at t = 2H + 2H*k, for k = 0..DATA_W-1.
- CPHA=0:
  - Sample MISO into a sample flop at each leading edge.
  - Shift {sr[DATA_W-2:0], sample} at each trailing edge.
- CPHA=1:
  - Sample MISO at each trailing edge.
  - Shift H cycles later: coincident with the next leading edge, or at t = 2H*DATA_W + H for the last bit.
- Completion at t = (2*DATA_W+1)*H: SS_n all high, busy 0, done 1, state IDLE, rd_data = shift register. For CPHA=0 this gives an H-cycle back porch after the last trailing edge.
- Exactly DATA_W shifts and DATA_W sample events per transfer. Bit counter width is clog2(DATA_W+1).
- wrt while busy=1: ignored; no effect on data, mode or select.
- wrt in the cycle done=1 (state IDLE): accepted as a normal start; done clears on the next edge.
- Mode inputs change mid-transfer: no effect until the next accepted wrt.
- rst_n asserted mid-transfer: immediate return to reset values; the partial word is discarded; no done pulse.
- rd_data holds its value until the next accepted wrt. Contents while busy=1 are undefined to consumers.

Optional Feature:
Macro SPI_LSB_FIRST_EN.
- Defined:
  - Adds input port lsb_first (1 bit), captured on accepted wrt.
  - When lsb_first=1: MOSI = shift register LSB; shifts insert the sample at the MSB ({sample, sr[DATA_W-1:1]}); rd_data is in natural bit order.
  - When lsb_first=0: behaviour identical to the macro being undefined.
- Undefined: port absent; MSB-first only.

Test Plan:
1. DATA_W=16, SCLK_DIV=32, mode 3 loopback (MISO=MOSI), wrt_data=16'hA5C3 -> SS_n falls at t=0, first SCLK fall at t=16, 32 SCLK edges, done=1 at t=528, rd_data=16'hA5C3.
2. Mode 0, slave model returning 16'h1234 while master sends 16'hBEEF -> slave captures 16'hBEEF, rd_data=16'h1234, SCLK idles low before and after.
3. NUM_SS=4, ss_sel=2 -> SS_n=4'b1011 during transfer, 4'b1111 otherwise. ss_sel=3 with NUM_SS=3 -> SS_n stays 3'b111, done still at t=528.
4. wrt pulse at t=100 with a different wrt_data -> ignored; rd_data matches the original transfer. wrt in the done cycle -> new transfer starts; done low the next cycle.
5. rst_n low at t=200 -> SS_n=1, SCLK=1, busy=0, done=0 within the same cycle. A following transfer completes normally.
6. SPI_LSB_FIRST_EN defined, lsb_first=1, loopback 16'h0001 -> first MOSI bit 1; rd_data=16'h0001.
